// File: rtl/pc_sequencer_pkg.sv
// Shared types and constants for the program-counter / fetch sequencer.
// The fetch/execute/trap state encoding lives here so the top and the bench agree on it.
package pc_sequencer_pkg;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    EXEC  = 2'd1,
    TRAP  = 2'd2
  } state_t;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  // addi x0, x0, 0
  localparam logic [31:0] NOP = 32'h00000013;

  // No compressed-instruction support, so any target off a 4-byte boundary is illegal.
  function automatic logic is_misaligned(input logic [1:0] i_lsb);
    return i_lsb != 2'b00;
  endfunction

endpackage

// File: rtl/pc_sequencer_branch_compare.sv
// Conditional-branch resolution: decodes Funct3 against the ALU compare flags.
// Purely combinational; reserved encodings 010/011 never take the branch.
module branch_compare
  import pc_sequencer_pkg::*;
(
  input  logic       i_branch,
  input  logic [2:0] i_funct3,
  input  logic       i_zero,
  input  logic       i_less_than,
  input  logic       i_less_than_u,
  output logic       o_taken
);

  logic w_cond;

  always_comb begin
    w_cond = 1'b0;
    case (i_funct3)
      F3_BEQ:  w_cond = i_zero;
      F3_BNE:  w_cond = !i_zero;
      F3_BLT:  w_cond = i_less_than;
      F3_BGE:  w_cond = !i_less_than;
      F3_BLTU: w_cond = i_less_than_u;
      F3_BGEU: w_cond = !i_less_than_u;
      default: w_cond = 1'b0;
    endcase
  end

  assign o_taken = i_branch && w_cond;

endmodule

// File: rtl/pc_sequencer.sv
// Program counter and request/acknowledge fetch sequencer with branch/jump target selection,
// misaligned-target trap redirect and a 64-bit retired-instruction counter.
module pc_sequencer
  import pc_sequencer_pkg::*;
#(
  parameter int unsigned XLEN         = 32,
  parameter logic [63:0] RESET_VECTOR = 64'h0,
  parameter logic [63:0] TRAP_VECTOR  = 64'h100
) (
  input  logic            clock,
  input  logic            Reset,
  input  logic            Stall,
  output logic            IReq,
  output logic [XLEN-1:0] IAddr,
  input  logic            IAck,
  input  logic [31:0]     IData,
  output logic [31:0]     Instruction,
  output logic            InstrValid,
  input  logic            Branch,
  input  logic            Jal,
  input  logic            Jalr,
  input  logic [2:0]      Funct3,
  input  logic            Zero,
  input  logic            LessThan,
  input  logic            LessThanU,
  input  logic [XLEN-1:0] Imm,
  input  logic [XLEN-1:0] RS1,
  output logic [XLEN-1:0] PC,
  output logic [XLEN-1:0] PCPlus4,
  output logic            Trap,
  output logic [XLEN-1:0] BadAddr,
  output logic [63:0]     Retired
);

  localparam logic [XLEN-1:0] LP_RESET_PC = RESET_VECTOR[XLEN-1:0];
  localparam logic [XLEN-1:0] LP_TRAP_PC  = TRAP_VECTOR[XLEN-1:0];
  localparam logic [XLEN-1:0] LP_FOUR     = XLEN'(4);

  state_t r_state;
  state_t w_next_state;

  logic [XLEN-1:0] r_pc;
  logic [31:0]     r_instr;
  logic [XLEN-1:0] r_bad_addr;
  logic [63:0]     r_retired;

  logic            w_ireq;
  logic            w_instr_valid;
  logic            w_trap;
  logic            w_taken;
  logic            w_redirect;
  logic            w_misaligned;
  logic            w_exec_go;
  logic            w_fetch_done;
  logic [XLEN-1:0] w_pc_plus4;
  logic [XLEN-1:0] w_jalr_sum;
  logic [XLEN-1:0] w_jalr_target;
  logic [XLEN-1:0] w_rel_target;
  logic [XLEN-1:0] w_target;

  branch_compare u_branch_compare (
    .i_branch      (Branch),
    .i_funct3      (Funct3),
    .i_zero        (Zero),
    .i_less_than   (LessThan),
    .i_less_than_u (LessThanU),
    .o_taken       (w_taken)
  );

  assign w_pc_plus4    = r_pc + LP_FOUR;
  assign w_jalr_sum    = RS1 + Imm;
  assign w_jalr_target = {w_jalr_sum[XLEN-1:1], 1'b0};
  assign w_rel_target  = r_pc + Imm;

  // Jalr > Jal > taken branch > fall-through; only redirected targets can trap.
  always_comb begin
    w_target   = w_pc_plus4;
    w_redirect = 1'b0;
    if (Jalr) begin
      w_target   = w_jalr_target;
      w_redirect = 1'b1;
    end else if (Jal || w_taken) begin
      w_target   = w_rel_target;
      w_redirect = 1'b1;
    end
  end

  assign w_misaligned = w_redirect && is_misaligned(w_target[1:0]);
  assign w_exec_go    = (r_state == EXEC) && !Stall;
  assign w_fetch_done = (r_state == FETCH) && IAck;

  always_ff @(posedge clock or posedge Reset) begin
    if (Reset) begin
      r_state <= FETCH;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state  = r_state;
    w_ireq        = 1'b0;
    w_instr_valid = 1'b0;
    w_trap        = 1'b0;
    case (r_state)
      FETCH: begin
        w_ireq = 1'b1;
        if (IAck) begin
          w_next_state = EXEC;
        end
      end
      EXEC: begin
        w_instr_valid = 1'b1;
        if (!Stall) begin
          w_next_state = w_misaligned ? TRAP : FETCH;
        end
      end
      TRAP: begin
        w_trap       = 1'b1;
        w_next_state = FETCH;
      end
      default: w_next_state = FETCH;
    endcase
  end

  always_ff @(posedge clock or posedge Reset) begin
    if (Reset) begin
      r_pc       <= LP_RESET_PC;
      r_instr    <= 32'h0;
      r_bad_addr <= '0;
      r_retired  <= 64'h0;
    end else begin
      if (w_fetch_done) begin
        r_instr <= IData;
      end
      if (w_exec_go) begin
        if (w_misaligned) begin
          r_bad_addr <= w_target;
          r_pc       <= LP_TRAP_PC;
        end else begin
          r_pc      <= w_target;
          r_retired <= r_retired + 64'd1;
        end
      end
    end
  end

  // Gate with Reset so the handshake drops in the same cycle Reset rises.
  assign IReq        = w_ireq && !Reset;
  assign InstrValid  = w_instr_valid && !Reset;
  assign Trap        = w_trap && !Reset;
  assign IAddr       = r_pc;
  assign PC          = r_pc;
  assign PCPlus4     = w_pc_plus4;
  assign Instruction = r_instr;
  assign BadAddr     = r_bad_addr;
  assign Retired     = r_retired;

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Parametrised program-counter and fetch sequencer for the RISC-V core, replacing the fixed 32-bit PC, +4 adder and branch-target path with one block. It holds the PC and runs a request/acknowledge instruction fetch. It evaluates all six conditional branches plus JAL/JALR, redirects misaligned targets to a trap vector, and counts retired instructions. It sits between instruction memory and decode; decode and ALU feed control back in the execute phase.

## Interface
Parameters:
- XLEN, 32, address/data width (32 or 64)
- RESET_VECTOR, 0, PC after reset
- TRAP_VECTOR, 'h100, PC after misaligned-target trap

Ports:
- clock  in  1  single clock, rising edge
- Reset  in  1  asynchronous, active-high; clears all state immediately
- Stall  in  1  holds the execute phase; PC and state frozen
- IReq  out  1  fetch request, level, held until IAck
- IAddr  out  XLEN  fetch address, equals PC
- IAck  in  1  fetch complete this cycle; IData valid
- IData  in  32  instruction word
- Instruction  out  32  registered fetched word
- InstrValid  out  1  Instruction valid, execute phase active
- Branch, Jal, Jalr  in  1 each  control from decode
- Funct3  in  3  branch type
- Zero, LessThan, LessThanU  in  1 each  ALU compare flags for rs1 vs rs2
- Imm  in  XLEN  sign-extended immediate
- RS1  in  XLEN  register rs1 value
- PC  out  XLEN  address of current instruction
- PCPlus4  out  XLEN  PC+4, link value, combinational
- Trap  out  1  one-cycle pulse on misaligned target
- BadAddr  out  XLEN  captured offending target
- Retired  out  64  retired-instruction counter

## Operation
- States are FETCH, EXEC and TRAP.
- FETCH: IReq=1, IAddr=PC. When IAck=1, register IData into Instruction and go to EXEC.
- EXEC: InstrValid=1. If Stall=1, hold. If Stall=0, compute target, update PC, increment Retired and go to FETCH. If the target is misaligned, go to TRAP instead.
- Target priority is Jalr > Jal > taken branch > PC+4.
  - Jalr: (RS1+Imm) with bit 0 cleared.
  - Jal and taken branch: PC+Imm.
- Branch taken when Branch=1 and Funct3 gives a true condition:
  - BEQ 000: Zero
  - BNE 001: !Zero
  - BLT 100: LessThan
  - BGE 101: !LessThan
  - BLTU 110: LessThanU
  - BGEU 111: !LessThanU
  - Funct3 010 or 011: not taken.
- Misaligned means target[1:0]≠0. Only redirected (non-PC+4) targets are checked.
- On a misaligned target:
  - Trap pulses for one cycle and BadAddr ← target.
  - PC ← TRAP_VECTOR and Retired is not incremented.
  - TRAP lasts one cycle, then FETCH.
- All adds wrap modulo 2^XLEN. Retired wraps at 2^64.

## Timing
- Reset values:
  - PC=IAddr=RESET_VECTOR, PCPlus4=RESET_VECTOR+4
  - IReq=0, Instruction=0, InstrValid=0, Trap=0, BadAddr=0, Retired=0
  - state=FETCH
- First IReq=1 in the first cycle with Reset low.
- Fetch latency is one cycle minimum: IAck with IReq gives InstrValid next cycle. Best-case throughput is one instruction per 2 cycles.
- IAck while IReq=0 is ignored. IReq never drops before IAck, except on Reset.
- Control inputs are sampled only on the EXEC edge with Stall=0. Stall is ignored in FETCH and TRAP.
- Reset mid-fetch or mid-stall: IReq and InstrValid drop asynchronously, and any pending fetch is abandoned.

## Structure
- Package pc_sequencer_pkg holds:
  - state enum {FETCH, EXEC, TRAP}
  - funct3 constants F3_BEQ … F3_BGEU
  - NOP constant 32'h00000013 for bench use
- One sub-module, branch_compare: combinational Funct3+flags → taken.

## Test plan
- Reset and first fetch: Reset released, IAck after 3 cycles with IData=32'h00500093 → IReq high 3 cycles, IAddr=0, then InstrValid=1 and Instruction=32'h00500093.
- Sequential execution: 4 instructions, no control inputs → PC 0,4,8,C; Retired=4.
- Branch matrix: PC=0x40, Imm=0x20, all six Funct3 values with each flag polarity → PC=0x60 when taken, else 0x44.
- JALR: RS1=0x1001, Imm=4, Jalr=1 with Branch=1 also set → PC=0x1004 (bit 0 cleared, Jalr wins); PCPlus4 equals old PC+4.
- Misaligned trap: Jal=1, PC=0x40, Imm=2 → Trap pulse, BadAddr=0x42, next IAddr=TRAP_VECTOR, Retired unchanged.
- Stall and reset: Stall held 5 cycles in EXEC → PC and Retired frozen. Reset asserted during IReq → IReq=0 same cycle, PC=RESET_VECTOR.
